// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the sram host-side controller:
// FSM encodings, strobe polarities and a small helper.
package sram_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_TURN  = 3'd4;

  localparam logic CS_ON = 1'b1;
  localparam logic WR_ON = 1'b1;
  localparam logic RD_ON = 1'b0;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Host request/response channel of the sram controller.
// The master issues requests; the slave (controller) answers.
interface sram_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 8
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_cyc_cnt.sv
// Loadable down-counter that stops at zero and flags it.
// Times the strobe phase of an sram access.
module sram_cyc_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Host-side initiator for the async 8-bit sram macro.
// One access at a time: SETUP, strobe phase, TURN, back to IDLE.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int WR_CYC = 1,
  parameter int RD_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_ctrl_if.slave    bus,
  output logic          sram_cs,
  output logic          sram_wr,
  output logic          sram_rd,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
);

  localparam int CW = $clog2(imax(WR_CYC, RD_CYC) + 1);
  localparam logic [CW-1:0] WR_LD = CW'(WR_CYC - 1);
  localparam logic [CW-1:0] RD_LD = CW'(RD_CYC - 1);

  logic [2:0]    r_state;
  logic          r_we;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;
  logic          w_load;
  logic [CW-1:0] w_ld_val;
  logic          w_zero;

  assign w_load   = (r_state == ST_SETUP);
  assign w_ld_val = r_we ? WR_LD : RD_LD;

  sram_cyc_cnt #(.W(CW)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_val  (w_ld_val),
    .o_zero (w_zero)
  );

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      sram_cs     <= ~CS_ON;
      sram_wr     <= ~WR_ON;
      sram_rd     <= ~RD_ON;
      sram_addr   <= '0;
      sram_din    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_state   <= ST_SETUP;
            r_we      <= bus.req_we;
            sram_cs   <= CS_ON;
            sram_addr <= bus.req_addr;
            sram_din  <= bus.req_wdata;
          end
        end
        ST_SETUP: begin
          if (r_we) begin
            r_state <= ST_WRITE;
            sram_wr <= WR_ON;
          end else begin
            r_state <= ST_READ;
            sram_rd <= RD_ON;
          end
        end
        ST_WRITE: begin
          if (w_zero) begin
            r_state     <= ST_TURN;
            sram_wr     <= ~WR_ON;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
          end
        end
        ST_READ: begin
          // dout is valid only while rd is still asserted
          if (w_zero) begin
            r_state     <= ST_TURN;
            sram_rd     <= ~RD_ON;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= sram_dout;
          end
        end
        ST_TURN: begin
          r_state <= ST_IDLE;
          sram_cs <= ~CS_ON;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_we        <= 1'b0;
          sram_cs     <= ~CS_ON;
          sram_wr     <= ~WR_ON;
          sram_rd     <= ~RD_ON;
          sram_addr   <= '0;
          sram_din    <= '0;
          r_rsp_rdata <= '0;
        end
      endcase
    end
  end

endmodule
